hazard_stall_unit: RTL and testbench

//  Backward-flowing control for the 5-stage MIPS pipeline. Forward stages push instructions IF->ID->EX;

---
 rtl/hazard_stall_unit_pkg.sv | 30 +++
 rtl/hazard_stall_unit_if.sv | 46 ++++
 rtl/hazard_stall_unit_detect.sv | 38 +++
 rtl/hazard_stall_unit.sv | 109 ++++++++++
 tb/tb_hazard_stall_unit.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Includes the FSM state encoding, stall lengths and the register-match helper.
package hazard_stall_unit_pkg;

    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned PERF_W      = 32;
    localparam int unsigned FLUSH_W     = 16;
    localparam int unsigned STALL_CNT_W = 2;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_STALL = 1'b1
    } state_t;

    localparam logic [STALL_CNT_W-1:0] NO_STALL     = 2'd0;
    localparam logic [STALL_CNT_W-1:0] LU_STALL     = 2'd1;
    localparam logic [STALL_CNT_W-1:0] BR_LD_STALL  = 2'd2;
    localparam logic [STALL_CNT_W-1:0] BR_ALU_STALL = 2'd1;

    // $0 is hardwired zero, so it never creates a dependency.
    function automatic logic regMatch(
        input logic [REG_ADDR_W-1:0] dst,
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rt,
        input logic                  usesRt
    );
        return (dst != '0) && ((dst == rs) || (usesRt && (dst == rt)));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Control bundle between the pipeline datapath and the hazard/stall controller.
// master = datapath side (drives hazard info), slave = the controller.
interface hazard_stall_unit_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned PERF_W     = 32,
    parameter int unsigned FLUSH_W    = 16
);
    logic [REG_ADDR_W-1:0] if_id_Rs;
    logic [REG_ADDR_W-1:0] if_id_Rt;
    logic                  id_uses_rt;
    logic                  id_is_branch;
    logic                  id_is_jump;
    logic                  branch_taken;
    logic                  id_ex_MemRead;
    logic                  id_ex_RegWrite;
    logic [REG_ADDR_W-1:0] id_ex_DstReg;
    logic                  ex_mem_MemRead;
    logic [REG_ADDR_W-1:0] ex_mem_DstReg;
    logic                  ext_stall;

    logic                  PCWrite;
    logic                  if_id_Write;
    logic                  if_id_Flush;
    logic                  id_ex_Bubble;
    logic                  pipe_freeze;
    logic                  stall_active;
    logic [PERF_W-1:0]     stall_cycles;
    logic [FLUSH_W-1:0]    flush_count;

    modport master (
        output if_id_Rs, if_id_Rt, id_uses_rt, id_is_branch, id_is_jump, branch_taken,
               id_ex_MemRead, id_ex_RegWrite, id_ex_DstReg, ex_mem_MemRead, ex_mem_DstReg,
               ext_stall,
        input  PCWrite, if_id_Write, if_id_Flush, id_ex_Bubble, pipe_freeze, stall_active,
               stall_cycles, flush_count
    );

    modport slave (
        input  if_id_Rs, if_id_Rt, id_uses_rt, id_is_branch, id_is_jump, branch_taken,
               id_ex_MemRead, id_ex_RegWrite, id_ex_DstReg, ex_mem_MemRead, ex_mem_DstReg,
               ext_stall,
        output PCWrite, if_id_Write, if_id_Flush, id_ex_Bubble, pipe_freeze, stall_active,
               stall_cycles, flush_count
    );

endinterface

// File: rtl/hazard_stall_unit_detect.sv
// Combinational hazard classifier: returns how many stall cycles the ID
// instruction needs given what sits in EX and MEM.
module hazard_stall_unit_detect
    import hazard_stall_unit_pkg::*;
(
    input  logic [REG_ADDR_W-1:0]  rs,
    input  logic [REG_ADDR_W-1:0]  rt,
    input  logic                   usesRt,
    input  logic                   isBranch,
    input  logic                   exMemRead,
    input  logic                   exRegWrite,
    input  logic [REG_ADDR_W-1:0]  exDst,
    input  logic                   memMemRead,
    input  logic [REG_ADDR_W-1:0]  memDst,
    output logic [STALL_CNT_W-1:0] stallNum
);

    logic exMatch;
    logic memMatch;

    assign exMatch  = regMatch(exDst, rs, rt, usesRt);
    assign memMatch = regMatch(memDst, rs, rt, usesRt);

    // Branch operands are compared in ID, so results must be ready one stage earlier than usual.
    always_comb begin
        stallNum = NO_STALL;
        if (isBranch && exMemRead && exMatch) begin
            stallNum = BR_LD_STALL;
        end else if (exMemRead && exMatch) begin
            stallNum = LU_STALL;
        end else if (isBranch && exRegWrite && exMatch) begin
            stallNum = BR_ALU_STALL;
        end else if (isBranch && memMemRead && memMatch) begin
            stallNum = LU_STALL;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Backward-flowing pipeline control: stall sequencing, IF/ID flush, global
// freeze on external stall, and saturating stall/flush statistics.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned PERF_W  = hazard_stall_unit_pkg::PERF_W,
    parameter int unsigned FLUSH_W = hazard_stall_unit_pkg::FLUSH_W
)(
    input  logic               Clk,
    input  logic               Rst,
    hazard_stall_unit_if.slave hif
);

    state_t                 state;
    state_t                 stateNext;
    logic [STALL_CNT_W-1:0] remain;
    logic [STALL_CNT_W-1:0] remainNext;
    logic [STALL_CNT_W-1:0] stallNum;
    logic [PERF_W-1:0]      stallCycles;
    logic [FLUSH_W-1:0]     flushCount;

    hazard_stall_unit_detect uDetect (
        .rs         (hif.if_id_Rs),
        .rt         (hif.if_id_Rt),
        .usesRt     (hif.id_uses_rt),
        .isBranch   (hif.id_is_branch),
        .exMemRead  (hif.id_ex_MemRead),
        .exRegWrite (hif.id_ex_RegWrite),
        .exDst      (hif.id_ex_DstReg),
        .memMemRead (hif.ex_mem_MemRead),
        .memDst     (hif.ex_mem_DstReg),
        .stallNum   (stallNum)
    );

    // State register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state  <= S_RUN;
            remain <= '0;
        end else begin
            state  <= stateNext;
            remain <= remainNext;
        end
    end

    // Next state: ext_stall holds everything; hazards are only sampled in RUN
    always_comb begin
        stateNext  = state;
        remainNext = remain;
        if (!hif.ext_stall) begin
            if (state == S_RUN) begin
                if (stallNum != NO_STALL) begin
                    remainNext = stallNum - STALL_CNT_W'(1);
                    stateNext  = (stallNum > STALL_CNT_W'(1)) ? S_STALL : S_RUN;
                end
            end else begin
                remainNext = remain - STALL_CNT_W'(1);
                if (remain == STALL_CNT_W'(1)) begin
                    stateNext = S_RUN;
                end
            end
        end
    end

    // Outputs are same-cycle so a detected hazard blocks the very next edge
    always_comb begin
        hif.PCWrite      = 1'b1;
        hif.if_id_Write  = 1'b1;
        hif.if_id_Flush  = 1'b0;
        hif.id_ex_Bubble = 1'b0;
        hif.pipe_freeze  = 1'b0;
        hif.stall_active = 1'b0;
        if (!Rst) begin
            hif.PCWrite      = 1'b0;
            hif.if_id_Write  = 1'b0;
            hif.id_ex_Bubble = 1'b1;
        end else if (hif.ext_stall) begin
            hif.pipe_freeze  = 1'b1;
            hif.PCWrite      = 1'b0;
            hif.if_id_Write  = 1'b0;
        end else if ((state == S_STALL) || (stallNum != NO_STALL)) begin
            hif.PCWrite      = 1'b0;
            hif.if_id_Write  = 1'b0;
            hif.id_ex_Bubble = 1'b1;
            hif.stall_active = 1'b1;
        end else begin
            hif.if_id_Flush  = hif.id_is_jump | (hif.id_is_branch & hif.branch_taken);
        end
    end

    // Saturating statistics
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stallCycles <= '0;
            flushCount  <= '0;
        end else begin
            if (hif.stall_active && (stallCycles != {PERF_W{1'b1}})) begin
                stallCycles <= stallCycles + PERF_W'(1);
            end
            if (hif.if_id_Flush && (flushCount != {FLUSH_W{1'b1}})) begin
                flushCount <= flushCount + FLUSH_W'(1);
            end
        end
    end

    assign hif.stall_cycles = stallCycles;
    assign hif.flush_count  = flushCount;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: load-use, branch hazards, freeze,
// mid-stall reset and counter saturation (narrow counters for reachability).
module tb_hazard_stall_unit;

    localparam int unsigned TB_PERF_W  = 4;
    localparam int unsigned TB_FLUSH_W = 3;

    logic Clk;
    logic Rst;
    int   assertCnt;
    int   failCnt;

    hazard_stall_unit_if #(.REG_ADDR_W(5), .PERF_W(TB_PERF_W), .FLUSH_W(TB_FLUSH_W)) hif ();

    hazard_stall_unit #(.PERF_W(TB_PERF_W), .FLUSH_W(TB_FLUSH_W)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .hif (hif)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCnt++;
        if (obs !== exp) begin
            failCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic setIdle();
        hif.if_id_Rs       = 5'd0;
        hif.if_id_Rt       = 5'd0;
        hif.id_uses_rt     = 1'b0;
        hif.id_is_branch   = 1'b0;
        hif.id_is_jump     = 1'b0;
        hif.branch_taken   = 1'b0;
        hif.id_ex_MemRead  = 1'b0;
        hif.id_ex_RegWrite = 1'b0;
        hif.id_ex_DstReg   = 5'd0;
        hif.ex_mem_MemRead = 1'b0;
        hif.ex_mem_DstReg  = 5'd0;
        hif.ext_stall      = 1'b0;
    endtask

    // lw $dst in EX, branch $rs,$rt in ID
    task automatic setBranchLoad(input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic taken);
        setIdle();
        hif.id_ex_MemRead  = 1'b1;
        hif.id_ex_RegWrite = 1'b1;
        hif.id_ex_DstReg   = dst;
        hif.if_id_Rs       = rs;
        hif.if_id_Rt       = rt;
        hif.id_uses_rt     = 1'b1;
        hif.id_is_branch   = 1'b1;
        hif.branch_taken   = taken;
    endtask

    task automatic checkStallOuts(input string tag);
        checkVal({tag, ".stall"},  32'(hif.stall_active), 32'd1);
        checkVal({tag, ".pc"},     32'(hif.PCWrite),      32'd0);
        checkVal({tag, ".ifid"},   32'(hif.if_id_Write),  32'd0);
        checkVal({tag, ".bubble"}, 32'(hif.id_ex_Bubble), 32'd1);
        checkVal({tag, ".flush"},  32'(hif.if_id_Flush),  32'd0);
    endtask

    task automatic checkResetOuts(input string tag);
        checkVal({tag, ".pc"},     32'(hif.PCWrite),      32'd0);
        checkVal({tag, ".ifid"},   32'(hif.if_id_Write),  32'd0);
        checkVal({tag, ".bubble"}, 32'(hif.id_ex_Bubble), 32'd1);
        checkVal({tag, ".flush"},  32'(hif.if_id_Flush),  32'd0);
        checkVal({tag, ".freeze"}, 32'(hif.pipe_freeze),  32'd0);
        checkVal({tag, ".stall"},  32'(hif.stall_active), 32'd0);
        checkVal({tag, ".scnt"},   32'(hif.stall_cycles), 32'd0);
        checkVal({tag, ".fcnt"},   32'(hif.flush_count),  32'd0);
    endtask

    initial begin
        assertCnt = 0;
        failCnt   = 0;
        Rst       = 1'b0;
        setIdle();

        // Reset values
        @(negedge Clk);
        #1;
        checkResetOuts("rst");
        Rst = 1'b1;
        step();

        // lw $2 in EX, add $3,$2,$4 in ID: one stall cycle
        setIdle();
        hif.id_ex_MemRead  = 1'b1;
        hif.id_ex_RegWrite = 1'b1;
        hif.id_ex_DstReg   = 5'd2;
        hif.if_id_Rs       = 5'd2;
        hif.if_id_Rt       = 5'd4;
        hif.id_uses_rt     = 1'b1;
        #1;
        checkStallOuts("lu");
        step();
        setIdle();
        #1;
        checkVal("lu.resume.pc", 32'(hif.PCWrite),      32'd1);
        checkVal("lu.resume.st", 32'(hif.stall_active), 32'd0);
        checkVal("lu.scnt",      32'(hif.stall_cycles), 32'd1);
        step();

        // lw $5 in EX, beq $5,$6 in ID: two stalls, then taken flush
        setBranchLoad(5'd5, 5'd5, 5'd6, 1'b1);
        #1;
        checkStallOuts("brld.c1");
        step();
        setIdle();
        hif.ex_mem_MemRead = 1'b1;
        hif.ex_mem_DstReg  = 5'd5;
        hif.if_id_Rs       = 5'd5;
        hif.if_id_Rt       = 5'd6;
        hif.id_uses_rt     = 1'b1;
        hif.id_is_branch   = 1'b1;
        hif.branch_taken   = 1'b1;
        #1;
        checkStallOuts("brld.c2");
        checkVal("brld.c2.scnt", 32'(hif.stall_cycles), 32'd2);
        step();
        hif.ex_mem_MemRead = 1'b0;
        hif.ex_mem_DstReg  = 5'd0;
        #1;
        checkVal("brld.flush",  32'(hif.if_id_Flush),  32'd1);
        checkVal("brld.pc",     32'(hif.PCWrite),      32'd1);
        checkVal("brld.stall",  32'(hif.stall_active), 32'd0);
        checkVal("brld.scnt",   32'(hif.stall_cycles), 32'd3);
        step();
        setIdle();
        #1;
        checkVal("brld.flush1", 32'(hif.if_id_Flush),  32'd0);
        checkVal("brld.fcnt",   32'(hif.flush_count),  32'd1);
        step();

        // lw $0 in EX, add $3,$0,$0 in ID: $0 never matches
        setIdle();
        hif.id_ex_MemRead  = 1'b1;
        hif.id_ex_RegWrite = 1'b1;
        hif.id_uses_rt     = 1'b1;
        #1;
        checkVal("zero.pc",    32'(hif.PCWrite),      32'd1);
        checkVal("zero.stall", 32'(hif.stall_active), 32'd0);
        step();
        #1;
        checkVal("zero.pc2",   32'(hif.PCWrite),      32'd1);
        checkVal("zero.scnt",  32'(hif.stall_cycles), 32'd3);
        step();

        // Two-cycle branch stall frozen by ext_stall on the second stall cycle
        setBranchLoad(5'd7, 5'd7, 5'd8, 1'b0);
        #1;
        checkStallOuts("frz.c1");
        step();
        for (int i = 0; i < 3; i++) begin
            hif.ext_stall = 1'b1;
            #1;
            checkVal("frz.freeze", 32'(hif.pipe_freeze),  32'd1);
            checkVal("frz.pc",     32'(hif.PCWrite),      32'd0);
            checkVal("frz.bubble", 32'(hif.id_ex_Bubble), 32'd0);
            checkVal("frz.stall",  32'(hif.stall_active), 32'd0);
            checkVal("frz.scnt",   32'(hif.stall_cycles), 32'd4);
            step();
        end
        hif.ext_stall = 1'b0;
        #1;
        checkStallOuts("frz.resume");
        checkVal("frz.nofreeze", 32'(hif.pipe_freeze), 32'd0);
        step();
        setIdle();
        hif.if_id_Rs     = 5'd7;
        hif.if_id_Rt     = 5'd8;
        hif.id_uses_rt   = 1'b1;
        hif.id_is_branch = 1'b1;
        #1;
        checkVal("frz.run.pc",    32'(hif.PCWrite),      32'd1);
        checkVal("frz.run.flush", 32'(hif.if_id_Flush),  32'd0);
        checkVal("frz.run.stall", 32'(hif.stall_active), 32'd0);
        checkVal("frz.scnt",      32'(hif.stall_cycles), 32'd5);
        step();

        // Reset asserted while in STALL
        setBranchLoad(5'd12, 5'd12, 5'd3, 1'b0);
        #1;
        checkVal("rs.c1.stall", 32'(hif.stall_active), 32'd1);
        step();
        setIdle();
        #1;
        checkVal("rs.c2.stall", 32'(hif.stall_active), 32'd1);
        checkVal("rs.c2.scnt",  32'(hif.stall_cycles), 32'd6);
        Rst = 1'b0;
        #1;
        checkResetOuts("rs.mid");
        step();
        Rst = 1'b1;
        #1;
        checkVal("rs.after.pc",    32'(hif.PCWrite),      32'd1);
        checkVal("rs.after.stall", 32'(hif.stall_active), 32'd0);
        step();

        // Rt only counts when the ID instruction reads it
        setIdle();
        hif.id_ex_MemRead  = 1'b1;
        hif.id_ex_RegWrite = 1'b1;
        hif.id_ex_DstReg   = 5'd4;
        hif.if_id_Rs       = 5'd1;
        hif.if_id_Rt       = 5'd4;
        #1;
        checkVal("rt.unused", 32'(hif.stall_active), 32'd0);
        hif.id_uses_rt = 1'b1;
        #1;
        checkVal("rt.used",   32'(hif.stall_active), 32'd1);
        step();

        // ALU result in EX: forwarded for ALU ops, one stall for a branch
        setIdle();
        hif.id_ex_RegWrite = 1'b1;
        hif.id_ex_DstReg   = 5'd9;
        hif.if_id_Rs       = 5'd9;
        hif.if_id_Rt       = 5'd2;
        hif.id_uses_rt     = 1'b1;
        #1;
        checkVal("alu.nobr", 32'(hif.stall_active), 32'd0);
        hif.id_is_branch = 1'b1;
        #1;
        checkVal("alu.br",   32'(hif.stall_active), 32'd1);
        step();
        setIdle();
        #1;
        checkVal("alu.run",  32'(hif.stall_active), 32'd0);
        checkVal("alu.scnt", 32'(hif.stall_cycles), 32'd2);
        step();

        // Load in MEM feeding a branch in ID (via Rt)
        setIdle();
        hif.ex_mem_MemRead = 1'b1;
        hif.ex_mem_DstReg  = 5'd11;
        hif.if_id_Rs       = 5'd5;
        hif.if_id_Rt       = 5'd11;
        hif.id_uses_rt     = 1'b1;
        hif.id_is_branch   = 1'b1;
        #1;
        checkVal("memld.stall", 32'(hif.stall_active), 32'd1);
        step();
        setIdle();
        #1;
        checkVal("memld.scnt",  32'(hif.stall_cycles), 32'd3);
        step();

        // Jump under ext_stall: freeze wins, no flush
        setIdle();
        hif.id_is_jump = 1'b1;
        hif.ext_stall  = 1'b1;
        #1;
        checkVal("jfrz.flush",  32'(hif.if_id_Flush), 32'd0);
        checkVal("jfrz.freeze", 32'(hif.pipe_freeze), 32'd1);
        step();
        setIdle();
        #1;
        checkVal("jfrz.fcnt",   32'(hif.flush_count), 32'd0);
        step();

        // Long load-use stream saturates stall_cycles
        setIdle();
        hif.id_ex_MemRead = 1'b1;
        hif.id_ex_DstReg  = 5'd6;
        hif.if_id_Rs      = 5'd6;
        for (int i = 0; i < 16; i++) step();
        #1;
        checkVal("sat.stall", 32'(hif.stall_active), 32'd1);
        checkVal("sat.scnt",  32'(hif.stall_cycles), 32'd15);
        step();
        #1;
        checkVal("sat.hold",  32'(hif.stall_cycles), 32'd15);
        step();

        // Jump stream saturates flush_count
        setIdle();
        hif.id_is_jump = 1'b1;
        for (int i = 0; i < 9; i++) step();
        #1;
        checkVal("fsat.flush", 32'(hif.if_id_Flush), 32'd1);
        checkVal("fsat.fcnt",  32'(hif.flush_count), 32'd7);
        setIdle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
